// File: rtl/packet_tx_arbiter.sv
// packet_tx_arbiter: round-robin two-source arbiter feeding the resampler byte input, with truncation and guard gap
module packet_tx_arbiter #(
  parameter int MAX_LEN = 2047,
  parameter int GAP_CYCLES = 16,
  parameter int START_TIMEOUT = 64
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic        en_a,
  input  logic [7:0]  data_a,
  input  logic        req_b,
  input  logic        en_b,
  input  logic [7:0]  data_b,
  input  logic [2:0]  phase_rx_in,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        enable_out,
  output logic [7:0]  data_out,
  output logic        pkt_done,
  output logic [10:0] pkt_len,
  output logic [7:0]  trunc_cnt,
  output logic [7:0]  timeout_cnt
);
  typedef enum logic [2:0] {IDLE, GRANT, PASS, TRUNC, GAP} state_t;
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);
  localparam logic [7:0] GAP_L = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] TOUT_L = 8'(START_TIMEOUT - 1);
  state_t state_q, state_d;
  logic sel_q, sel_d, last_b_q, last_b_d;
  logic gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic enable_q, enable_d, pkt_done_q, pkt_done_d;
  logic [7:0] data_q, data_d, wait_q, wait_d, gap_q, gap_d;
  logic [7:0] trunc_q, trunc_d, tout_q, tout_d;
  logic [10:0] pkt_len_q, pkt_len_d, byte_cnt_q, byte_cnt_d;
  logic en_g, req_g;
  logic [7:0] data_g;
  assign en_g = sel_q ? en_b : en_a;
  assign req_g = sel_q ? req_b : req_a;
  assign data_g = sel_q ? data_b : data_a;
  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;
  assign enable_out = enable_q;
  assign data_out = data_q;
  assign pkt_done = pkt_done_q;
  assign pkt_len = pkt_len_q;
  assign trunc_cnt = trunc_q;
  assign timeout_cnt = tout_q;
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= 1'b0;
      last_b_q <= 1'b1;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      enable_q <= 1'b0;
      pkt_done_q <= 1'b0;
      data_q <= '0;
      wait_q <= '0;
      gap_q <= '0;
      trunc_q <= '0;
      tout_q <= '0;
      pkt_len_q <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      last_b_q <= last_b_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      enable_q <= enable_d;
      pkt_done_q <= pkt_done_d;
      data_q <= data_d;
      wait_q <= wait_d;
      gap_q <= gap_d;
      trunc_q <= trunc_d;
      tout_q <= tout_d;
      pkt_len_q <= pkt_len_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    last_b_d = last_b_q;
    gnt_a_d = gnt_a_q;
    gnt_b_d = gnt_b_q;
    enable_d = 1'b0;
    pkt_done_d = 1'b0;
    data_d = data_q;
    wait_d = wait_q;
    gap_d = gap_q;
    trunc_d = trunc_q;
    tout_d = tout_q;
    pkt_len_d = pkt_len_q;
    byte_cnt_d = byte_cnt_q;
    case (state_q)
      IDLE: if (req_a || req_b) begin
        sel_d = (req_a && req_b) ? !last_b_q : req_b;
        last_b_d = sel_d;
        gnt_a_d = !sel_d;
        gnt_b_d = sel_d;
        wait_d = '0;
        state_d = GRANT;
      end
      GRANT: if (en_g) begin
        enable_d = 1'b1;
        data_d = data_g;
        byte_cnt_d = 11'd1;
        state_d = PASS;
      end else if (!req_g || wait_q == TOUT_L) begin
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        tout_d = (req_g && tout_q != 8'hff) ? tout_q + 8'd1 : tout_q;
        state_d = IDLE;
      end else begin
        wait_d = wait_q + 8'd1;
      end
      PASS: if (en_g && byte_cnt_q != MAX_L) begin
        enable_d = 1'b1;
        data_d = data_g;
        byte_cnt_d = byte_cnt_q + 11'd1;
      end else begin
        pkt_done_d = 1'b1;
        pkt_len_d = byte_cnt_q;
        if (en_g) begin
          trunc_d = (trunc_q != 8'hff) ? trunc_q + 8'd1 : trunc_q;
          state_d = TRUNC;
        end else begin
          gnt_a_d = 1'b0;
          gnt_b_d = 1'b0;
          gap_d = '0;
          state_d = GAP;
        end
      end
      TRUNC: if (!en_g) begin
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        gap_d = '0;
        state_d = GAP;
      end
      GAP: begin
        gap_d = (gap_q == GAP_L) ? gap_q : gap_q + 8'd1;
        state_d = (gap_q == GAP_L && phase_rx_in == 3'd0) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_packet_tx_arbiter.sv
// tb_packet_tx_arbiter: randomized packet traffic checked against a transaction-level model of the arbiter
module tb_packet_tx_arbiter;
  localparam int MAX_LEN = 32;
  localparam int GAP = 16;
  localparam int TOUT = 64;
  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0, en_a = 1'b0, req_b = 1'b0, en_b = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic [2:0] phase_rx_in = '0;
  logic gnt_a, gnt_b, enable_out, pkt_done;
  logic [7:0] data_out, trunc_cnt, timeout_cnt;
  logic [10:0] pkt_len;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int trunc_m = 0, tout_m = 0;
  bit last_b = 1'b1, fresh = 1'b1;
  logic [7:0] qdata[$];
  int qdone[$];
  packet_tx_arbiter #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP), .START_TIMEOUT(TOUT)) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .req_a(req_a), .en_a(en_a), .data_a(data_a),
    .req_b(req_b), .en_b(en_b), .data_b(data_b),
    .phase_rx_in(phase_rx_in),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .enable_out(enable_out), .data_out(data_out),
    .pkt_done(pkt_done), .pkt_len(pkt_len),
    .trunc_cnt(trunc_cnt), .timeout_cnt(timeout_cnt)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask
  always @(negedge clk_in) begin
    if (enable_out) qdata.push_back(data_out);
    if (pkt_done) qdone.push_back(int'(pkt_len));
    chk("gnt_excl", {31'd0, gnt_a & gnt_b}, 0);
  end
  task automatic drive(input bit s, input logic e, input logic [7:0] d);
    if (s) begin
      en_b = e;
      data_b = d;
    end else begin
      en_a = e;
      data_a = d;
    end
  endtask
  task automatic run_pkt(input int mask, input int len, input int w, input int busy, input bit early, input bit inc);
    int t0, exp_t;
    bit s;
    logic [7:0] b, lastb;
    logic [7:0] exp_q[$];
    t0 = cyc;
    s = (mask == 3) ? !last_b : (mask == 2);
    exp_t = fresh ? t0 + 1 : t0 + ((GAP > busy + 1) ? GAP : busy + 1) + 1;
    req_a = (mask & 1) != 0;
    req_b = (mask & 2) != 0;
    phase_rx_in = (busy > 0) ? 3'b101 : 3'b000;
    while (!(gnt_a || gnt_b) && cyc - t0 < 400) begin
      tick();
      phase_rx_in = (cyc - t0 < busy) ? 3'b101 : 3'b000;
    end
    phase_rx_in = '0;
    chk("gnt_time", cyc, exp_t);
    chk("gnt_src", {30'd0, gnt_b, gnt_a}, s ? 2 : 1);
    last_b = s;
    fresh = 1'b0;
    qdata.delete();
    qdone.delete();
    lastb = data_out;
    repeat (w) tick();
    for (int i = 0; i < len; i++) begin
      b = inc ? 8'(i + 1) : 8'($urandom);
      drive(s, 1'b1, b);
      drive(!s, 1'($urandom), 8'($urandom));
      if (i < MAX_LEN) begin
        exp_q.push_back(b);
        lastb = b;
      end
      if (early && i == 0) begin
        if (s) req_b = 1'b0;
        else req_a = 1'b0;
      end
      tick();
    end
    chk("gnt_hold", {31'd0, s ? gnt_b : gnt_a}, 1);
    drive(s, 1'b0, 8'($urandom));
    drive(!s, 1'b0, 8'd0);
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    chk("gnt_drop", {30'd0, gnt_b, gnt_a}, 0);
    chk("done_cnt", qdone.size(), 1);
    if (qdone.size() > 0) chk("done_len", qdone[0], exp_q.size());
    chk("pkt_len", {21'd0, pkt_len}, exp_q.size());
    chk("fwd_cnt", qdata.size(), exp_q.size());
    for (int i = 0; i < qdata.size() && i < exp_q.size(); i++) chk("fwd_byte", {24'd0, qdata[i]}, {24'd0, exp_q[i]});
    chk("data_hold", {24'd0, data_out}, {24'd0, lastb});
    chk("enable_low", {31'd0, enable_out}, 0);
    if (len > MAX_LEN && trunc_m < 255) trunc_m++;
    chk("trunc_cnt", {24'd0, trunc_cnt}, trunc_m);
    chk("tout_cnt", {24'd0, timeout_cnt}, tout_m);
  endtask
  task automatic settle();
    req_a = 1'b0;
    req_b = 1'b0;
    phase_rx_in = '0;
    repeat (GAP + 4) tick();
    fresh = 1'b1;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, {30'd0, gnt_b, gnt_a}, 0);
    chk({tag, "_en"}, {31'd0, enable_out}, 0);
    chk({tag, "_data"}, {24'd0, data_out}, 0);
    chk({tag, "_done"}, {31'd0, pkt_done}, 0);
    chk({tag, "_len"}, {21'd0, pkt_len}, 0);
    chk({tag, "_trunc"}, {24'd0, trunc_cnt}, 0);
    chk({tag, "_tout"}, {24'd0, timeout_cnt}, 0);
  endtask
  initial begin
    int tg, k;
    rst_n = 1'b0;
    repeat (3) tick();
    check_zero("rst");
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) run_pkt(3, 10, 0, 0, 0, 1);
    run_pkt(1, 20, 0, 100, 0, 1);
    run_pkt(1, 40, 1, 0, 0, 1);
    settle();
    run_pkt(1, 20, 0, 0, 0, 1);
    settle();
    req_b = 1'b1;
    tick();
    tg = cyc;
    chk("to_gnt_b", {31'd0, gnt_b}, 1);
    req_a = 1'b1;
    while (gnt_b && cyc - tg < 100) tick();
    chk("to_drop", cyc - tg, TOUT);
    tout_m++;
    chk("to_cnt", {24'd0, timeout_cnt}, tout_m);
    tick();
    chk("to_gnt_a", {31'd0, gnt_a}, 1);
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    chk("req_drop", {30'd0, gnt_b, gnt_a}, 0);
    last_b = 1'b0;
    settle();
    req_a = 1'b1;
    tick();
    chk("mid_gnt", {31'd0, gnt_a}, 1);
    qdone.delete();
    for (int i = 0; i < 5; i++) begin
      en_a = 1'b1;
      data_a = 8'(i + 1);
      if (i == 4) rst_n = 1'b0;
      tick();
    end
    check_zero("mid");
    chk("mid_nodone", qdone.size(), 0);
    rst_n = 1'b1;
    en_a = 1'b0;
    req_a = 1'b0;
    last_b = 1'b1;
    trunc_m = 0;
    tout_m = 0;
    fresh = 1'b1;
    tick();
    run_pkt(2, 20, 0, 0, 0, 1);
    for (int i = 0; i < 30; i++)
      run_pkt($urandom_range(1, 3), $urandom_range(1, 45), $urandom_range(0, 3),
              ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : 0, 1'($urandom), 1'b0);
    settle();
    req_b = 1'b1;
    k = 17500;
    repeat (k) tick();
    req_b = 1'b0;
    tick();
    tout_m = tout_m + k / (TOUT + 1);
    if (tout_m > 255) tout_m = 255;
    chk("tout_sat", {24'd0, timeout_cnt}, tout_m);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #5000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/packet_tx_arbiter.md
Name: packet_tx_arbiter

Overview:
- Shares the byte-wide input of the 8b-to-4b packet resampler between two packet sources, A and B. Runs in the resampler's input clock domain (25 MHz).
- Arbitration is round-robin with a request/grant handshake.
- Forwards the granted source's enable/data stream with one cycle of latency.
- Truncates oversize packets and inserts a guard gap. No new grant is issued until the resampler receive FSM reports idle.

Parameters:
MAX_LEN, 2047, maximum forwarded bytes per packet. Range 8..2047; must fit the resampler's 11-bit address.
GAP_CYCLES, 16, minimum idle cycles after a packet ends before re-arbitration. Range 1..255.
START_TIMEOUT, 64, cycles a grant may wait for the source's first enable before it is revoked. Range 1..255.

Ports:
clk_in  in  1  single clock; all logic on the rising edge.
rst_n  in  1  reset, synchronous, active-low.
req_a  in  1  source A requests access; level, held until granted.
en_a  in  1  source A packet enable; level, high for the whole packet.
data_a  in  8  source A byte; valid when en_a=1.
req_b / en_b / data_b  in  1/1/8  same as A, for source B.
gnt_a  out  1  grant to A (registered).
gnt_b  out  1  grant to B (registered).
phase_rx_in  in  3  resampler receive phase; 0 means idle.
enable_out  out  1  to resampler enable_in.
data_out  out  8  to resampler data_in.
pkt_done  out  1  one-cycle pulse when a forwarded packet ends.
pkt_len  out  11  byte count of the last forwarded packet; valid from pkt_done onward.
trunc_cnt  out  8  saturating count of truncated packets.
timeout_cnt  out  8  saturating count of grant timeouts.

Behaviour:
- Reset (rst_n=0 at a clock edge): all outputs 0, state IDLE, round-robin pointer set to favour A, all counters 0. A mid-packet reset drops enable_out the next cycle; no pkt_done is issued.
- States: IDLE, GRANT, PASS, TRUNC, GAP. "g" denotes the granted source.
- IDLE:
  - Only req_a: gnt_a<=1. Only req_b: gnt_b<=1.
  - Both: grant the source that was not granted last; the first-ever tie goes to A.
  - On any grant, go to GRANT and clear the wait counter.
  - gnt_a and gnt_b are never both 1.
- GRANT:
  - en_g=1: enable_out<=1, data_out<=data_g, byte_cnt<=1, go to PASS.
  - Else req_g=0: drop the grant, go to IDLE.
  - Else wait counter reaches START_TIMEOUT: drop the grant, timeout_cnt+1 (saturates at 255), go to IDLE.
- PASS (each cycle):
  - en_g=1 and byte_cnt<MAX_LEN: enable_out<=1, data_out<=data_g, byte_cnt+1.
  - en_g=1 and byte_cnt==MAX_LEN: enable_out<=0, pkt_len<=MAX_LEN, pkt_done<=1, trunc_cnt+1 (saturating), go to TRUNC with the grant held.
  - en_g=0: enable_out<=0, pkt_len<=byte_cnt, pkt_done<=1, grant dropped, gap counter cleared, go to GAP.
- TRUNC:
  - Discard data_g and keep enable_out=0.
  - When en_g=0: drop the grant, clear the gap counter, go to GAP.
- GAP:
  - Count GAP_CYCLES cycles.
  - Then wait until phase_rx_in==0; on the first such cycle go to IDLE.
  - Requests are not evaluated in GAP. The earliest new grant is one cycle after IDLE is entered.
- Latency and data rules:
  - data_out/enable_out lag data_g/en_g by exactly one cycle; the forwarded stream is contiguous.
  - en/data of the non-granted source are ignored at all times.
  - data_out holds its last value while enable_out=0.
- Boundaries:
  - req_g and en_g rising on the same cycle in GRANT: the packet is taken.
  - req_g dropping during PASS has no effect; the packet end is defined only by en_g.
  - A 1-byte packet gives pkt_len=1. The glitch filter is the resampler's job, not this block's.
  - Counters saturate at 255 and do not wrap.

Test Plan:
- Single request: req_a=1, grant observed, then 20-byte packet 0x01..0x14 on en_a/data_a -> gnt_a=1 one cycle after req_a. enable_out high exactly 20 cycles, data_out 0x01..0x14 with 1-cycle lag. pkt_done pulse with pkt_len=20. gnt_a drops on the cycle after en_a falls.
- Round-robin: req_a and req_b held high continuously, each sending a 10-byte packet per grant, phase_rx_in=0 -> grant order A,B,A,B. Each new grant comes GAP_CYCLES+1 cycles after the previous packet's last enable_out. Never both grants high.
- Resampler busy: phase_rx_in=3'b101 for 100 cycles after the packet -> no grant until 1 cycle after phase_rx_in returns to 0, regardless of GAP_CYCLES elapsing.
- Truncation with MAX_LEN=32: 40-byte packet -> enable_out high exactly 32 cycles, pkt_len=32, trunc_cnt=1. Bytes 33..40 are not forwarded. Grant is held until en_a falls.
- Timeout: req_b=1, en_b never asserted -> gnt_b drops START_TIMEOUT (64) cycles after it rose, timeout_cnt=1. A pending req_a is granted the following cycle.
- Reset mid-packet: rst_n=0 at byte 5 of 20 -> next edge all outputs 0, no pkt_done. After release, a fresh req_b is granted normally.
